// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state codes and baud divisor helper
package uart_pkg;
   localparam int DATA_BITS = 8;
   localparam int OVERSAMPLE = 16;
   localparam logic [3:0] MID_START = 4'd7;
   localparam logic [3:0] MID_BIT = 4'd15;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] STOP = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;
   // clocks per sample tick, rounded to nearest
   function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
      return (clk_freq + (baud * ovs) / 2) / (baud * ovs);
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick, one clk high every DIV clocks
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD = 9600,
   parameter int OVERSAMPLE = 16
) (
   input logic clk,
   input logic rst,
   output logic tick
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int W = $clog2(DIV > 1 ? DIV : 2);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] cnt;
   assign tick = cnt == LAST;
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
   end
   ovs_fixed: assert property (@(posedge clk) OVERSAMPLE == uart_pkg::OVERSAMPLE);
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with valid/ack handshake and two-byte display history
module uart_byte_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD = 9600,
   parameter int OVERSAMPLE = 16
) (
   input logic clk,
   input logic rst,
   input logic rx,
   input logic rx_ack,
   output logic [7:0] rx_data,
   output logic rx_valid,
   output logic frame_err,
   output logic overrun,
   output logic [7:0] last_byte,
   output logic [7:0] prev_byte
);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   logic tick, rx_m, rx_s;
   logic [2:0] state;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [DATA_BITS-1:0] shreg;
   uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
      .clk(clk), .rst(rst), .tick(tick)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shreg <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
         last_byte <= '0;
         prev_byte <= '0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         frame_err <= 1'b0;
         if (rx_ack && rx_valid) rx_valid <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: if (!rx_s) begin
                  state <= START;
                  cnt <= '0;
               end
               START: if (cnt == MID_START) begin
                  cnt <= '0;
                  idx <= '0;
                  state <= rx_s ? IDLE : DATA;
               end else cnt <= cnt + 4'd1;
               DATA: if (cnt == MID_BIT) begin
                  shreg[idx] <= rx_s;
                  cnt <= '0;
                  idx <= idx + 3'd1;
                  if (idx == LAST_BIT) state <= STOP;
               end else cnt <= cnt + 4'd1;
               STOP: if (cnt == MID_BIT) begin
                  cnt <= '0;
                  if (rx_s) begin
                     // a late ack in this same clk still counts, so only a truly unacked byte is lost
                     if (rx_valid && !rx_ack) overrun <= 1'b1;
                     rx_data <= shreg;
                     rx_valid <= 1'b1;
                     prev_byte <= last_byte;
                     last_byte <= shreg;
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state <= BREAK;
                  end
               end else cnt <= cnt + 4'd1;
               BREAK: if (rx_s) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: randomized frames checked against a frame-level reference model
module tb_uart_byte_receiver;
   localparam int BIT_CLK = 160;
   logic clk = 1'b0, rst, rx, rx_ack;
   logic [7:0] rx_data, last_byte, prev_byte;
   logic rx_valid, frame_err, overrun;
   int total = 0, bad = 0, ferr_cnt = 0;
   logic [7:0] m_data, m_last, m_prev;
   logic m_valid, m_ovr;
   int m_ferr = 0;
   uart_byte_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .overrun(overrun), .last_byte(last_byte), .prev_byte(prev_byte)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (frame_err) ferr_cnt++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".data"}, 32'(rx_data), 32'(m_data));
      check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
      check({tag, ".last"}, 32'(last_byte), 32'(m_last));
      check({tag, ".prev"}, 32'(prev_byte), 32'(m_prev));
      check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
      check({tag, ".ferr"}, 32'(ferr_cnt), 32'(m_ferr));
   endtask
   task automatic model_reset();
      m_data = 0; m_last = 0; m_prev = 0; m_valid = 0; m_ovr = 0;
   endtask
   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (stop_ok) begin
         if (m_valid) m_ovr = 1;
         m_data = b;
         m_valid = 1;
         m_prev = m_last;
         m_last = b;
      end else m_ferr++;
   endtask
   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      hold(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) hold(b[i], BIT_CLK);
      hold(stop_ok, BIT_CLK);
      model_frame(b, stop_ok);
   endtask
   task automatic send_and_check(input string tag, input logic [7:0] b);
      send_frame(b, 1'b1);
      hold(1'b1, 40);
      check_all(tag);
   endtask
   task automatic ack_pulse(input string tag);
      @(negedge clk) rx_ack = 1'b1;
      @(negedge clk) rx_ack = 1'b0;
      m_valid = 0;
      check({tag, ".ack"}, 32'(rx_valid), 32'(m_valid));
   endtask
   initial begin
      rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all("reset");
      hold(1'b1, 200);
      send_and_check("a5", 8'hA5);
      ack_pulse("a5");
      send_and_check("3c", 8'h3C);
      ack_pulse("3c");
      send_and_check("f0", 8'hF0);
      ack_pulse("f0");
      ack_pulse("idle_ack");
      send_and_check("12", 8'h12);
      send_and_check("34", 8'h34);
      send_frame(8'h55, 1'b0);
      hold(1'b0, 2000);
      check_all("break");
      hold(1'b1, 200);
      check_all("break_rel");
      send_and_check("01", 8'h01);
      hold(1'b0, 40);
      hold(1'b1, 200);
      check_all("glitch");
      for (int k = 0; k < 8; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if ($urandom_range(0, 1) == 1) ack_pulse("rnd");
         send_and_check("rnd", b);
      end
      hold(1'b0, BIT_CLK);
      for (int i = 0; i < 3; i++) hold(1'(8'h77 >> i), BIT_CLK);
      @(negedge clk) rst = 1'b1; rx = 1'b1;
      @(negedge clk) rst = 1'b0;
      model_reset();
      check_all("midrst");
      hold(1'b1, 400);
      send_and_check("88", 8'h88);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
